// File: rtl/capture_ctrl.sv
// Capture controller: records strobed samples into a ring buffer, and on a trigger
// captures post-trigger samples, then streams stored words newest first over ready/strobe.
module capture_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_in,
    input  logic             set_cnt_i,
    input  logic [31:0]      cmd_i,
    input  logic             run_i,
    input  logic             stb_i,
    input  logic [WIDTH-1:0] smpls_i,
    input  logic             tx_rdy_i,
    output logic             tx_stb_o,
    output logic [WIDTH-1:0] tx_o,
    output logic             busy_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = CNT_W + 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_FETCH,
        S_SEND,
        S_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CNT_W-1:0] rf_q, rf_d;
    logic [CNT_W-1:0] df_q, df_d;
    logic [CW-1:0]    dcnt_q, dcnt_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] tx_d;
    logic             tx_stb_d;
    logic             wr_en;
    logic [CW-1:0]    read_full;
    logic [CW-1:0]    read_cnt;
    logic [CW-1:0]    delay_cnt;
    logic             unused_cmd;

    logic [WIDTH-1:0] mem [DEPTH];

    // Programmed counts are 4*(field+1); the read count saturates at the buffer depth.
    assign read_full  = CW'({rf_q, 2'b00}) + CW'(4);
    assign delay_cnt  = CW'({df_q, 2'b00}) + CW'(4);
    assign read_cnt   = (32'(read_full) > DEPTH) ? CW'(DEPTH) : read_full;
    assign unused_cmd = ^cmd_i;

    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        rf_d     = rf_q;
        df_d     = df_q;
        dcnt_d   = dcnt_q;
        rem_d    = rem_q;
        tx_d     = tx_o;
        tx_stb_d = 1'b0;
        wr_en    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (stb_i) begin
                    wr_en  = 1'b1;
                    wptr_d = wptr_q + AW'(1);
                end
                if (set_cnt_i) begin
                    rf_d = cmd_i[CNT_W-1:0];
                    df_d = cmd_i[2*CNT_W-1:CNT_W];
                end
                if (run_i) begin
                    state_d = S_DELAY;
                    dcnt_d  = stb_i ? (delay_cnt - CW'(1)) : delay_cnt;
                end
            end
            S_DELAY: begin
                if (stb_i) begin
                    wr_en  = 1'b1;
                    wptr_d = wptr_q + AW'(1);
                    dcnt_d = dcnt_q - CW'(1);
                    // Readout starts at the address of the final delay sample.
                    if (dcnt_q == CW'(1)) begin
                        state_d = S_FETCH;
                        rptr_d  = wptr_q;
                        rem_d   = read_cnt;
                    end
                end
            end
            S_FETCH: state_d = S_SEND;
            S_SEND: begin
                if (tx_rdy_i) begin
                    tx_d     = rd_data_q;
                    tx_stb_d = 1'b1;
                    rptr_d   = rptr_q - AW'(1);
                    rem_d    = rem_q - CW'(1);
                    state_d  = S_HOLD;
                end
            end
            S_HOLD:  state_d = (rem_q == '0) ? S_IDLE : S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= S_IDLE;
            wptr_q   <= '0;
            rptr_q   <= '0;
            rf_q     <= '0;
            df_q     <= '0;
            dcnt_q   <= '0;
            rem_q    <= '0;
            tx_o     <= '0;
            tx_stb_o <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            rf_q     <= rf_d;
            df_q     <= df_d;
            dcnt_q   <= dcnt_d;
            rem_q    <= rem_d;
            tx_o     <= tx_d;
            tx_stb_o <= tx_stb_d;
            busy_o   <= (state_d != S_IDLE);
        end
    end

    // Ring buffer storage is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wptr_q] <= smpls_i;
        end
        if (state_q == S_FETCH) begin
            rd_data_q <= mem[rptr_q];
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Randomised self-checking bench for capture_ctrl against a ring-buffer reference model.
module tb_capture_ctrl;

    localparam int W = 8;
    localparam int D = 16;

    logic          clk_i = 1'b0;
    logic          rst_in = 1'b1;
    logic          set_cnt_i, run_i, stb_i, tx_rdy_i;
    logic [31:0]   cmd_i;
    logic [W-1:0]  smpls_i;
    logic          tx_stb_o, busy_o;
    logic [W-1:0]  tx_o;

    int errors = 0;
    int checks = 0;

    // Reference model: sample store, write position, programmed fields, last delay sample.
    logic [W-1:0]  m_mem [D];
    int            m_wp = 0;
    int            m_rf = 0;
    int            m_df = 0;
    int            m_last = 0;
    logic [W-1:0]  rx_q [$];

    always #5 clk_i = ~clk_i;

    capture_ctrl #(.WIDTH(W), .DEPTH(D), .CNT_W(16)) dut (
        .clk_i    (clk_i),
        .rst_in   (rst_in),
        .set_cnt_i(set_cnt_i),
        .cmd_i    (cmd_i),
        .run_i    (run_i),
        .stb_i    (stb_i),
        .smpls_i  (smpls_i),
        .tx_rdy_i (tx_rdy_i),
        .tx_stb_o (tx_stb_o),
        .tx_o     (tx_o),
        .busy_o   (busy_o)
    );

    function automatic int read_cnt();
        int r = 4 * (m_rf + 1);
        return (r > D) ? D : r;
    endfunction

    function automatic int delay_cnt();
        return 4 * (m_df + 1);
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        stb_i = 1'b0; run_i = 1'b0; set_cnt_i = 1'b0; smpls_i = '0; cmd_i = '0;
    endtask

    task automatic record(input logic [W-1:0] v, input logic run);
        stb_i = 1'b1; smpls_i = v; run_i = run;
        tick();
        stb_i = 1'b0; run_i = 1'b0;
        m_mem[m_wp] = v;
        m_last = m_wp;
        m_wp = (m_wp + 1) % D;
    endtask

    task automatic program_cnt(input int rf, input int df);
        set_cnt_i = 1'b1; cmd_i = {16'(df), 16'(rf)};
        tick();
        set_cnt_i = 1'b0; cmd_i = '0;
        m_rf = rf; m_df = df;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            record(W'($urandom), 1'b0);
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_in = 1'b0;
        #1;
        checks++;
        if (tx_stb_o !== 1'b0 || tx_o !== '0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: stb=%0b tx=%0h busy=%0b required 0/0/0", tx_stb_o, tx_o, busy_o);
        end
        repeat (3) begin
            tick();
            checks++;
            if (tx_stb_o !== 1'b0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: stb=%0b busy=%0b required 0/0", tx_stb_o, busy_o);
            end
        end
        @(negedge clk_i);
        rst_in = 1'b1;
        m_wp = 0; m_rf = 0; m_df = 0;
        tick();
    endtask

    // Run pulse (optionally with the first delay sample) followed by the remaining delay samples.
    task automatic trigger(input logic with_stb, input logic guard, input int base);
        int left = delay_cnt();
        int v = base;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL busy_idle: busy=%0b required 0", busy_o);
        end
        if (with_stb) begin
            record((base > 0) ? W'(v) : W'($urandom), 1'b1);
            v++; left--;
        end else begin
            run_i = 1'b1;
            tick();
            run_i = 1'b0;
        end
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_rise: busy=%0b required 1", busy_o);
        end
        while (left > 0) begin
            repeat ($urandom_range(0, 2)) begin
                if (guard) begin
                    set_cnt_i = 1'b1; cmd_i = $urandom; run_i = 1'b1;
                end
                tick();
                set_cnt_i = 1'b0; cmd_i = '0; run_i = 1'b0;
            end
            record((base > 0) ? W'(v) : W'($urandom), 1'b0);
            v++; left--;
        end
    endtask

    // Readout with ignored-input noise. mode 0: ready high, 1: random ready, 2: 5-cycle stall after word 0.
    task automatic collect(input int n, input int mode, input int stop_after);
        int got = 0;
        int cyc = 0;
        int last_cyc = 0;
        logic prev_stb = 1'b0;
        logic [W-1:0] prev_tx = tx_o;
        logic [W-1:0] exp;
        rx_q.delete();
        while (got < stop_after && cyc < 2000) begin
            stb_i = 1'($urandom_range(0, 1)); smpls_i = W'($urandom);
            run_i = 1'($urandom_range(0, 1)); set_cnt_i = 1'($urandom_range(0, 1)); cmd_i = $urandom;
            tx_rdy_i = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            tick(); cyc++;
            checks++;
            if ((tx_stb_o && prev_stb) || (!tx_stb_o && tx_o !== prev_tx)) begin
                errors++;
                $display("FAIL protocol: stb=%0b prev_stb=%0b tx=%0h prev_tx=%0h", tx_stb_o, prev_stb, tx_o, prev_tx);
            end
            if (tx_stb_o) begin
                exp = m_mem[(m_last - got + D) % D];
                checks++;
                if (tx_o !== exp) begin
                    errors++;
                    $display("FAIL word%0d: got %0h required %0h", got, tx_o, exp);
                end
                rx_q.push_back(tx_o);
                if (mode == 0) begin
                    checks++;
                    if (cyc - last_cyc != ((got == 0) ? 2 : 3)) begin
                        errors++;
                        $display("FAIL spacing%0d: got %0d cycles required %0d", got, cyc - last_cyc, (got == 0) ? 2 : 3);
                    end
                end
                last_cyc = cyc;
                got++;
                if (mode == 2 && got == 1 && got < stop_after) begin
                    tx_rdy_i = 1'b0;
                    repeat (5) begin
                        tick(); cyc++;
                        checks++;
                        if (tx_stb_o !== 1'b0 || tx_o !== exp) begin
                            errors++;
                            $display("FAIL backpressure: stb=%0b tx=%0h required 0/%0h", tx_stb_o, tx_o, exp);
                        end
                    end
                    tx_rdy_i = 1'b1;
                    tick(); cyc++;
                    exp = m_mem[(m_last - got + D) % D];
                    checks++;
                    if (tx_stb_o !== 1'b1 || tx_o !== exp) begin
                        errors++;
                        $display("FAIL bp_release: stb=%0b tx=%0h required 1/%0h", tx_stb_o, tx_o, exp);
                    end
                    rx_q.push_back(tx_o);
                    last_cyc = cyc;
                    got++;
                end
            end
            prev_stb = tx_stb_o;
            prev_tx = tx_o;
        end
        idle_inputs();
        tx_rdy_i = 1'b1;
        checks++;
        if (got != stop_after) begin
            errors++;
            $display("FAIL word_count: got %0d words required %0d", got, stop_after);
        end
        if (stop_after == n) begin
            checks++;
            if (busy_o !== 1'b1) begin
                errors++;
                $display("FAIL busy_hold: busy=%0b required 1", busy_o);
            end
            tick();
            checks++;
            if (busy_o !== 1'b0) begin
                errors++;
                $display("FAIL busy_fall: busy=%0b required 0", busy_o);
            end
            repeat (4) begin
                tick();
                checks++;
                if (tx_stb_o !== 1'b0) begin
                    errors++;
                    $display("FAIL extra_word: stb=%0b required 0", tx_stb_o);
                end
            end
        end
    endtask

    task automatic test_reset();
        #1;
        do_reset();
        fill(20);
        trigger(1'b1, 1'b0, 0);
        collect(4, 0, 4);
        fill(5);
        #2;
        do_reset();
        trigger(1'b0, 1'b0, 0);
        collect(4, 0, 4);
    endtask

    task automatic test_basic();
        program_cnt(1, 0);
        for (int v = 1; v <= 9; v++) begin
            record(W'(v), 1'b0);
            tick();
        end
        record(W'(10), 1'b1);
        for (int v = 11; v <= 13; v++) begin
            tick();
            record(W'(v), 1'b0);
        end
        collect(8, 0, 8);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (rx_q[k] !== W'(13 - k)) begin
                errors++;
                $display("FAIL basic_order%0d: got %0h required %0h", k, rx_q[k], 13 - k);
            end
        end
    endtask

    task automatic test_backpressure();
        fill(3);
        trigger(1'b0, 1'b0, 0);
        collect(8, 2, 8);
    endtask

    task automatic test_guard();
        repeat (3) begin
            program_cnt(int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
            fill(int'($urandom_range(2, 6)));
            trigger(1'($urandom_range(0, 1)), 1'b1, 0);
            collect(read_cnt(), 1, read_cnt());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        program_cnt(3, 0);
        for (int v = 1; v <= 40; v++) record(W'(v), 1'b0);
        trigger(1'b0, 1'b0, 41);
        collect(16, 0, 16);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (rx_q[k] !== W'(44 - k)) begin
                errors++;
                $display("FAIL wrap_order%0d: got %0h required %0h", k, rx_q[k], 44 - k);
            end
        end
        program_cnt(7, 0);
        trigger(1'b1, 1'b0, 0);
        collect(read_cnt(), 0, read_cnt());
        checks++;
        if (rx_q.size() != 16) begin
            errors++;
            $display("FAIL saturation: got %0d words required 16", rx_q.size());
        end
    endtask

    task automatic test_reset_mid_send();
        program_cnt(1, 0);
        trigger(1'b1, 1'b0, 0);
        collect(8, 0, 3);
        do_reset();
        repeat (10) begin
            tick();
            checks++;
            if (tx_stb_o !== 1'b0) begin
                errors++;
                $display("FAIL post_abort: stb=%0b required 0", tx_stb_o);
            end
        end
        trigger(1'b0, 1'b0, 0);
        collect(4, 0, 4);
    endtask

    initial begin
        idle_inputs();
        tx_rdy_i = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_guard();
        test_wrap();
        test_reset_mid_send();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
